// File: rtl/clk_div_pkg.sv
// Shared types and default constants for the clock-divider controller.
// The optional period counter is enabled with CLK_DIV_CTRL_PERIOD_CNT_EN.
package clk_div_pkg;

  localparam int CNT_W_DFLT   = 16;
  localparam int BURST_W_DFLT = 8;
  localparam int DEF_DIV_DFLT = 50000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    BURST = 2'd3
  } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter with registered toggle output and rising-edge tick.
// Counting stops and the counter clears whenever run is low.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic             load_ok,
  output logic             wrap,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] count;

  assign load_ok = (count == '0);
  // Greater-or-equal keeps the counter bounded if H shrinks below the current count.
  assign wrap    = (count >= (div - CNT_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!run) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (wrap) begin
      count   <= '0;
      clk_out <= ~clk_out;
      tick    <= ~clk_out;
    end else begin
      count <= count + CNT_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop, burst and divisor-handshake controller around clk_div_core.
// Defining CLK_DIV_CTRL_PERIOD_CNT_EN adds a saturating period_cnt output.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DFLT,
  parameter int               BURST_W = BURST_W_DFLT,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_DFLT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_div,
  output logic               cfg_ready,
  input  logic               burst_start,
  input  logic [BURST_W-1:0] burst_len,
  output logic               busy,
  output logic               clk_out,
  output logic               tick,
  output logic [CNT_W-1:0]   div_cur
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]        period_cnt
`endif
);

  state_t             state;
  state_t             next_state;
  logic [BURST_W-1:0] remaining;
  logic [CNT_W-1:0]   pend_div;
  logic               run;
  logic               load_ok;
  logic               wrap;

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .div    (div_cur),
    .load_ok(load_ok),
    .wrap   (wrap),
    .clk_out(clk_out),
    .tick   (tick)
  );

  // Stopping while the output is low clears the counter; a stop on the
  // falling toggle keeps run high so that toggle still happens.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (burst_start && (burst_len != '0)) next_state = BURST;
        else if (en)                          next_state = RUN;
      end
      RUN: begin
        if (!en) begin
          if (!clk_out || wrap) next_state = IDLE;
          else                  next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (en)        next_state = RUN;
        else if (wrap) next_state = IDLE;
      end
      BURST: begin
        if (wrap && clk_out && (remaining <= BURST_W'(1))) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    run = (state != IDLE) && !((next_state == IDLE) && !clk_out);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      remaining <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      if ((state == IDLE) && (next_state == BURST))
        remaining <= burst_len;
      else if ((state == BURST) && wrap && clk_out)
        remaining <= remaining - BURST_W'(1);
    end
  end

  // A captured divisor waits in pend_div until a count==0 cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_ready <= 1'b1;
      pend_div  <= DEF_DIV;
      div_cur   <= DEF_DIV;
    end else if (cfg_valid && cfg_ready) begin
      pend_div  <= (cfg_div == '0) ? CNT_W'(1) : cfg_div;
      cfg_ready <= 1'b0;
    end else if (!cfg_ready && load_ok) begin
      div_cur   <= pend_div;
      cfg_ready <= 1'b1;
    end
  end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      period_cnt <= '0;
    else if ((state == IDLE) && (next_state != IDLE))
      period_cnt <= '0;
    else if (tick && (period_cnt != 16'hFFFF))
      period_cnt <= period_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: randomized directed steps compared
// against a half-period-position reference model.
module tb_clk_div_ctrl;

  localparam int         CNT_W   = 16;
  localparam int         BURST_W = 8;
  localparam logic [15:0] DEF_H  = 16'd5;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic               cfg_valid;
  logic [CNT_W-1:0]   cfg_div;
  logic               cfg_ready;
  logic               burst_start;
  logic [BURST_W-1:0] burst_len;
  logic               busy;
  logic               clk_out;
  logic               tick;
  logic [CNT_W-1:0]   div_cur;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0]        period_cnt;
`endif

  clk_div_ctrl #(
    .CNT_W  (CNT_W),
    .BURST_W(BURST_W),
    .DEF_DIV(DEF_H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .burst_start(burst_start),
    .burst_len  (burst_len),
    .busy       (busy),
    .clk_out    (clk_out),
    .tick       (tick),
    .div_cur    (div_cur)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: output level, position inside the current half-period,
  // active H, pending divisor and remaining burst periods.
  bit m_active, m_burst, m_lvl, m_tick, m_pend_v;
  int m_pos, m_h, m_pend, m_left;

  int n_cmp = 0;
  int n_err = 0;
  int tick_seen = 0;

  function void model_reset();
    m_active = 0; m_burst = 0; m_lvl = 0; m_tick = 0; m_pend_v = 0;
    m_pos = 0; m_h = int'(DEF_H); m_pend = 0; m_left = 0;
  endfunction

  function void model_step(input bit e, input bit bs, input int bl, input bit cv, input int cd);
    bit at_start;
    at_start = (m_pos == 0);
    m_tick = 0;
    if (!m_active) begin
      if (bs && bl != 0) begin m_active = 1; m_burst = 1; m_left = bl; end
      else if (e) begin m_active = 1; m_burst = 0; end
    end else if (!m_burst && !e && !m_lvl) begin
      m_active = 0;
      m_pos = 0;
    end else if (m_pos == m_h - 1) begin
      m_pos = 0;
      m_lvl = !m_lvl;
      m_tick = m_lvl;
      if (!m_lvl) begin
        if (m_burst) begin
          m_left--;
          if (m_left == 0) m_active = 0;
        end else if (!e) begin
          m_active = 0;
        end
      end
    end else begin
      m_pos++;
    end
    if (m_pend_v && at_start) begin
      m_h = m_pend; m_pend_v = 0;
    end else if (cv && !m_pend_v) begin
      m_pend = (cd == 0) ? 1 : cd; m_pend_v = 1;
    end
  endfunction

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkOne("clk_out",   32'(clk_out),   32'(m_lvl));
    checkOne("tick",      32'(tick),      32'(m_tick));
    checkOne("busy",      32'(busy),      32'(m_active));
    checkOne("cfg_ready", 32'(cfg_ready), 32'(!m_pend_v));
    checkOne("div_cur",   32'(div_cur),   32'(m_h));
    if (tick === 1'b1) tick_seen++;
  endtask

  task automatic applyStimulus(input bit e, input bit bs, input int bl, input bit cv, input int cd);
    en          = e;
    burst_start = bs;
    burst_len   = BURST_W'(bl);
    cfg_valid   = cv;
    cfg_div     = CNT_W'(cd);
    model_step(e, bs, bl, cv, cd);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic configIdle(input int h);
    applyStimulus(0, 0, 0, 1, h);
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    int len;
    int hold;
    bit e_r;

    reset = 1'b1; en = 0; cfg_valid = 0; cfg_div = '0; burst_start = 0; burst_len = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    checkOutput();
    reset = 1'b0;

    $display("[TB] free run at reset divisor");
    for (int i = 0; i < 32; i++) applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] divisor change while running, source holds valid");
    hold = $urandom_range(1, 8);
    for (int i = 0; i < hold; i++) applyStimulus(1, 0, 0, 1, 3);
    for (int i = 0; i < 24; i++) applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] stop and drain");
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0);
    e_r = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) e_r = !e_r;
      applyStimulus(e_r, 0, 0, 0, 0);
    end
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] counted bursts");
    applyStimulus(0, 1, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      configIdle($urandom_range(1, 4));
      len = $urandom_range(1, 4);
      tick_seen = 0;
      applyStimulus(0, 1, len, 0, 0);
      for (int i = 0; i < 100 && m_active; i++) applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), 2, 0, 0);
      checkOne("burst_ticks", 32'(tick_seen), 32'(len));
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0);
    end

    $display("[TB] zero divisor clamps to one");
    configIdle(0);
    checkOne("div_zero_clamp", 32'(div_cur), 32'd1);
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] random mixed traffic");
    e_r = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) e_r = !e_r;
      applyStimulus(e_r, ($urandom_range(0, 19) == 0), $urandom_range(0, 3),
                    ($urandom_range(0, 9) == 0), $urandom_range(2, 6));
    end
    for (int i = 0; i < 30 && m_active; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] asynchronous reset mid-burst");
    configIdle(3);
    applyStimulus(0, 1, 5, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOne("pre_reset_clk_out", 32'(clk_out), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOne("async_clk_out",   32'(clk_out),   32'd0);
    checkOne("async_tick",      32'(tick),      32'd0);
    checkOne("async_busy",      32'(busy),      32'd0);
    checkOne("async_cfg_ready", 32'(cfg_ready), 32'd1);
    checkOne("async_div_cur",   32'(div_cur),   32'(DEF_H));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
